dispatcher: RTL and testbench

Issue stage between the instruction decoder and the execution back end. Each cycle it accepts at most one decoded instruction and allocates a ROB entry for it. It renames the destination in the register file and resolves both source operands to value or ROB tag, forwarding from the register file, the ROB and both CDBs. It then delivers a registered packet to the arithmetic reservation station or to the load/store buffer.

---
 rtl/dispatcher.sv | 227 ++++++++++++++++++++++
 tb/tb_dispatcher.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatcher.sv
// Issue stage: allocates a ROB entry, renames rd, resolves both sources through RF/ROB/CDBs and
// registers one packet for the arithmetic RS or the LSB (enable visible the cycle after accept).

module dispatcher #(
   parameter int ROB_W  = 4,
   parameter int DATA_W = 32,
   parameter int OP_W   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   // decoder side
   input  logic              dec_valid,
   output logic              dec_ready,
   input  logic [OP_W-1:0]   dec_openum,
   input  logic [4:0]        dec_rd,
   input  logic [4:0]        dec_rs1,
   input  logic [4:0]        dec_rs2,
   input  logic              dec_use_rs1,
   input  logic              dec_use_rs2,
   input  logic              dec_is_ls,
   input  logic [DATA_W-1:0] dec_imm,
   input  logic [DATA_W-1:0] dec_pc,
   // register file query
   output logic [4:0]        rf_rs1,
   output logic [4:0]        rf_rs2,
   input  logic [ROB_W-1:0]  rf_q1,
   input  logic [ROB_W-1:0]  rf_q2,
   input  logic [DATA_W-1:0] rf_v1,
   input  logic [DATA_W-1:0] rf_v2,
   // ROB query and allocation
   output logic [ROB_W-1:0]  rob_q1,
   output logic [ROB_W-1:0]  rob_q2,
   input  logic              rob_rdy1,
   input  logic              rob_rdy2,
   input  logic [DATA_W-1:0] rob_val1,
   input  logic [DATA_W-1:0] rob_val2,
   input  logic [ROB_W-1:0]  rob_free_id,
   input  logic              rob_full,
   output logic              rob_alloc,
   output logic [4:0]        rob_alloc_rd,
   output logic [OP_W-1:0]   rob_alloc_openum,
   output logic [DATA_W-1:0] rob_alloc_pc,
   // rename
   output logic              rename_en,
   output logic [4:0]        rename_rd,
   output logic [ROB_W-1:0]  rename_id,
   // RS / LSB packet
   input  logic              rs_full,
   input  logic              lsb_full,
   output logic              rs_enable,
   output logic              lsb_enable,
   output logic [OP_W-1:0]   out_openum,
   output logic [ROB_W-1:0]  out_q1,
   output logic [ROB_W-1:0]  out_q2,
   output logic [DATA_W-1:0] out_v1,
   output logic [DATA_W-1:0] out_v2,
   output logic [DATA_W-1:0] out_imm,
   output logic [DATA_W-1:0] out_pc,
   output logic [ROB_W-1:0]  out_rob_id,
   // common data buses
   input  logic              cdb_a_valid,
   input  logic [ROB_W-1:0]  cdb_a_id,
   input  logic [DATA_W-1:0] cdb_a_res,
   input  logic              cdb_ls_valid,
   input  logic [ROB_W-1:0]  cdb_ls_id,
   input  logic [DATA_W-1:0] cdb_ls_res,
   input  logic              misbranch
);

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   typedef struct packed {
      logic [ROB_W-1:0]  q;
      logic [DATA_W-1:0] v;
   } opnd_t;

   // Priority: unused/x0, RF value, ROB result, arithmetic CDB, load/store CDB, else wait on tag.
   function automatic opnd_t resolve(
      input logic              use_src,
      input logic [4:0]        idx,
      input logic [ROB_W-1:0]  rq,
      input logic [DATA_W-1:0] rv,
      input logic              rrdy,
      input logic [DATA_W-1:0] rval,
      input logic              av,
      input logic [ROB_W-1:0]  aid,
      input logic [DATA_W-1:0] ares,
      input logic              lv,
      input logic [ROB_W-1:0]  lid,
      input logic [DATA_W-1:0] lres
   );
      opnd_t res;
      res.q = '0;
      res.v = '0;
      if (!use_src || idx == 5'd0) begin
         res.q = '0;
         res.v = '0;
      end else if (rq == '0) begin
         res.v = rv;
      end else if (rrdy) begin
         res.v = rval;
      end else if (av && aid == rq) begin
         res.v = ares;
      end else if (lv && lid == rq) begin
         res.v = lres;
      end else begin
         res.q = rq;
      end
      return res;
   endfunction

   state_t r_state;
   state_t w_state_nxt;
   logic   w_flush_hold;
   logic   w_tgt_full;
   logic   w_fire;
   opnd_t  w_op1;
   opnd_t  w_op2;

   logic              r_rs_en;
   logic              r_lsb_en;
   logic [OP_W-1:0]   r_openum;
   logic [ROB_W-1:0]  r_q1;
   logic [ROB_W-1:0]  r_q2;
   logic [DATA_W-1:0] r_v1;
   logic [DATA_W-1:0] r_v2;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_pc;
   logic [ROB_W-1:0]  r_rob_id;

   // Handshake
   assign w_tgt_full = dec_is_ls ? lsb_full : rs_full;
   assign dec_ready  = rdy && !rob_full && !w_tgt_full && !misbranch && !w_flush_hold;
   assign w_fire     = dec_valid && dec_ready;

   // Lookups are pure pass-through so RF and ROB answer within the same cycle
   assign rf_rs1 = dec_rs1;
   assign rf_rs2 = dec_rs2;
   assign rob_q1 = rf_q1;
   assign rob_q2 = rf_q2;

   assign w_op1 = resolve(dec_use_rs1, dec_rs1, rf_q1, rf_v1, rob_rdy1, rob_val1,
                          cdb_a_valid, cdb_a_id, cdb_a_res, cdb_ls_valid, cdb_ls_id, cdb_ls_res);
   assign w_op2 = resolve(dec_use_rs2, dec_rs2, rf_q2, rf_v2, rob_rdy2, rob_val2,
                          cdb_a_valid, cdb_a_id, cdb_a_res, cdb_ls_valid, cdb_ls_id, cdb_ls_res);

   // ROB allocation and rename commit on the same edge that loads the packet
   assign rob_alloc        = w_fire;
   assign rob_alloc_rd     = dec_rd;
   assign rob_alloc_openum = dec_openum;
   assign rob_alloc_pc     = dec_pc;
   assign rename_en        = w_fire && (dec_rd != 5'd0);
   assign rename_rd        = dec_rd;
   assign rename_id        = rob_free_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
      end else if (rdy) begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_flush_hold = 1'b0;
      case (r_state)
         S_RUN: begin
            if (misbranch) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            // One dead cycle lets the ROB and RS finish clearing before new issue
            w_flush_hold = 1'b1;
            if (!misbranch) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rs_en  <= 1'b0;
         r_lsb_en <= 1'b0;
         r_openum <= '0;
         r_q1     <= '0;
         r_q2     <= '0;
         r_v1     <= '0;
         r_v2     <= '0;
         r_imm    <= '0;
         r_pc     <= '0;
         r_rob_id <= '0;
      end else if (rdy) begin
         if (misbranch) begin
            r_rs_en  <= 1'b0;
            r_lsb_en <= 1'b0;
            r_openum <= '0;
         end else if (w_fire) begin
            r_rs_en  <= !dec_is_ls;
            r_lsb_en <= dec_is_ls;
            r_openum <= dec_openum;
            r_q1     <= w_op1.q;
            r_q2     <= w_op2.q;
            r_v1     <= w_op1.v;
            r_v2     <= w_op2.v;
            r_imm    <= dec_imm;
            r_pc     <= dec_pc;
            r_rob_id <= rob_free_id;
         end else begin
            r_rs_en  <= 1'b0;
            r_lsb_en <= 1'b0;
         end
      end
   end

   assign rs_enable  = r_rs_en;
   assign lsb_enable = r_lsb_en;
   assign out_openum = r_openum;
   assign out_q1     = r_q1;
   assign out_q2     = r_q2;
   assign out_v1     = r_v1;
   assign out_v2     = r_v2;
   assign out_imm    = r_imm;
   assign out_pc     = r_pc;
   assign out_rob_id = r_rob_id;

endmodule

// File: tb/tb_dispatcher.sv
// Self-checking bench for dispatcher: directed scenarios followed by randomized traffic
// compared against a cycle-level behavioural model.

module tb_dispatcher;
   localparam int ROB_W  = 4;
   localparam int DATA_W = 32;
   localparam int OP_W   = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, rdy, dec_valid, dec_ready;
   logic [OP_W-1:0]   dec_openum;
   logic [4:0]        dec_rd, dec_rs1, dec_rs2;
   logic              dec_use_rs1, dec_use_rs2, dec_is_ls;
   logic [DATA_W-1:0] dec_imm, dec_pc;
   logic [4:0]        rf_rs1, rf_rs2;
   logic [ROB_W-1:0]  rf_q1, rf_q2;
   logic [DATA_W-1:0] rf_v1, rf_v2;
   logic [ROB_W-1:0]  rob_q1, rob_q2;
   logic              rob_rdy1, rob_rdy2;
   logic [DATA_W-1:0] rob_val1, rob_val2;
   logic [ROB_W-1:0]  rob_free_id;
   logic              rob_full, rob_alloc;
   logic [4:0]        rob_alloc_rd;
   logic [OP_W-1:0]   rob_alloc_openum;
   logic [DATA_W-1:0] rob_alloc_pc;
   logic              rename_en;
   logic [4:0]        rename_rd;
   logic [ROB_W-1:0]  rename_id;
   logic              rs_full, lsb_full, rs_enable, lsb_enable;
   logic [OP_W-1:0]   out_openum;
   logic [ROB_W-1:0]  out_q1, out_q2, out_rob_id;
   logic [DATA_W-1:0] out_v1, out_v2, out_imm, out_pc;
   logic              cdb_a_valid, cdb_ls_valid;
   logic [ROB_W-1:0]  cdb_a_id, cdb_ls_id;
   logic [DATA_W-1:0] cdb_a_res, cdb_ls_res;
   logic              misbranch;

   int checks = 0;
   int failures = 0;

   dispatcher #(.ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_openum(dec_openum),
      .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_is_ls(dec_is_ls),
      .dec_imm(dec_imm), .dec_pc(dec_pc),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_q1(rf_q1), .rf_q2(rf_q2),
      .rf_v1(rf_v1), .rf_v2(rf_v2),
      .rob_q1(rob_q1), .rob_q2(rob_q2), .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2),
      .rob_val1(rob_val1), .rob_val2(rob_val2), .rob_free_id(rob_free_id),
      .rob_full(rob_full), .rob_alloc(rob_alloc), .rob_alloc_rd(rob_alloc_rd),
      .rob_alloc_openum(rob_alloc_openum), .rob_alloc_pc(rob_alloc_pc),
      .rename_en(rename_en), .rename_rd(rename_rd), .rename_id(rename_id),
      .rs_full(rs_full), .lsb_full(lsb_full), .rs_enable(rs_enable), .lsb_enable(lsb_enable),
      .out_openum(out_openum), .out_q1(out_q1), .out_q2(out_q2),
      .out_v1(out_v1), .out_v2(out_v2), .out_imm(out_imm), .out_pc(out_pc),
      .out_rob_id(out_rob_id),
      .cdb_a_valid(cdb_a_valid), .cdb_a_id(cdb_a_id), .cdb_a_res(cdb_a_res),
      .cdb_ls_valid(cdb_ls_valid), .cdb_ls_id(cdb_ls_id), .cdb_ls_res(cdb_ls_res),
      .misbranch(misbranch)
   );

   task automatic idle_inputs();
      rdy = 1'b1; dec_valid = 1'b0; dec_openum = '0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0;
      dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_is_ls = 1'b0; dec_imm = '0; dec_pc = '0;
      rf_q1 = '0; rf_q2 = '0; rf_v1 = '0; rf_v2 = '0; rob_rdy1 = 1'b0; rob_rdy2 = 1'b0;
      rob_val1 = '0; rob_val2 = '0; rob_free_id = 4'd1; rob_full = 1'b0;
      rs_full = 1'b0; lsb_full = 1'b0; cdb_a_valid = 1'b0; cdb_a_id = '0; cdb_a_res = '0;
      cdb_ls_valid = 1'b0; cdb_ls_id = '0; cdb_ls_res = '0; misbranch = 1'b0;
   endtask

   // Advance one clock; inputs may be changed on return, outputs settled
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({rs_enable, lsb_enable, out_openum, out_q1, out_q2, out_v1, out_v2, out_imm, out_pc, out_rob_id} !== '0) begin
         failures++;
         $display("FAIL reset_packet got en=%b/%b op=%h q=%h/%h v=%h/%h id=%h want all zero",
                  rs_enable, lsb_enable, out_openum, out_q1, out_q2, out_v1, out_v2, out_rob_id);
      end
      checks++;
      if (dec_ready !== 1'b1) begin failures++; $display("FAIL reset_dec_ready got=%b want=1", dec_ready); end
   endtask

   task automatic test_basic_add();
      idle_inputs();
      dec_valid = 1'b1; dec_openum = 6'h01; dec_rd = 5'd1; dec_rs1 = 5'd2; dec_rs2 = 5'd3;
      dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; rf_v1 = 32'd5; rf_v2 = 32'd7;
      dec_imm = 32'h0000_0010; dec_pc = 32'h0000_1000; rob_free_id = 4'd1;
      #1;
      checks++;
      if ({dec_ready, rob_alloc, rename_en} !== 3'b111) begin
         failures++; $display("FAIL add_accept got ready/alloc/rename=%b want=111", {dec_ready, rob_alloc, rename_en});
      end
      checks++;
      if ({rename_rd, rename_id, rf_rs1, rf_rs2} !== {5'd1, 4'd1, 5'd2, 5'd3}) begin
         failures++; $display("FAIL add_rename_query got rd=%0d id=%0d rs=%0d/%0d want 1 1 2 3",
                              rename_rd, rename_id, rf_rs1, rf_rs2);
      end
      tick();
      dec_valid = 1'b0;
      checks++;
      if ({rs_enable, lsb_enable} !== 2'b10) begin
         failures++; $display("FAIL add_enable got rs/lsb=%b want=10", {rs_enable, lsb_enable});
      end
      checks++;
      if ({out_v1, out_v2, out_q1, out_q2, out_rob_id, out_openum, out_pc} !==
          {32'd5, 32'd7, 4'd0, 4'd0, 4'd1, 6'h01, 32'h0000_1000}) begin
         failures++; $display("FAIL add_packet got v=%0d/%0d q=%0d/%0d id=%0d op=%h pc=%h want 5/7 0/0 1 01 1000",
                              out_v1, out_v2, out_q1, out_q2, out_rob_id, out_openum, out_pc);
      end
      tick();
      checks++;
      if ({rs_enable, lsb_enable} !== 2'b00) begin
         failures++; $display("FAIL add_pulse_end got rs/lsb=%b want=00", {rs_enable, lsb_enable});
      end
   endtask

   task automatic test_cdb_forward();
      for (int pass = 0; pass < 2; pass++) begin
         idle_inputs();
         dec_valid = 1'b1; dec_openum = 6'h02; dec_rd = 5'd6; dec_rs1 = 5'd5; dec_use_rs1 = 1'b1;
         rf_q1 = 4'd3; rf_v1 = 32'hDEAD; rob_free_id = 4'd4;
         if (pass == 0) begin cdb_a_valid = 1'b1; cdb_a_id = 4'd3; cdb_a_res = 32'h2A;
                              cdb_ls_valid = 1'b1; cdb_ls_id = 4'd9; cdb_ls_res = 32'h55; end
         else begin cdb_ls_valid = 1'b1; cdb_ls_id = 4'd3; cdb_ls_res = 32'h2A;
                    cdb_a_valid = 1'b1; cdb_a_id = 4'd7; cdb_a_res = 32'h66; end
         #1;
         checks++;
         if (rob_q1 !== 4'd3) begin failures++; $display("FAIL cdb_rob_query%0d got=%0d want=3", pass, rob_q1); end
         tick();
         dec_valid = 1'b0;
         checks++;
         if ({out_q1, out_v1} !== {4'd0, 32'h2A}) begin
            failures++; $display("FAIL cdb_forward%0d got q=%0d v=%h want q=0 v=2a", pass, out_q1, out_v1);
         end
      end
   endtask

   task automatic test_dependent_chain();
      idle_inputs();
      dec_valid = 1'b1; dec_openum = 6'h01; dec_rd = 5'd1; dec_rs1 = 5'd2; dec_use_rs1 = 1'b1;
      rf_v1 = 32'd9; rob_free_id = 4'd2;
      #1;
      checks++;
      if ({rename_en, rename_id} !== {1'b1, 4'd2}) begin
         failures++; $display("FAIL dep_rename got en=%b id=%0d want en=1 id=2", rename_en, rename_id);
      end
      tick();
      // Second instruction issues back-to-back, reading the just-renamed tag
      dec_openum = 6'h03; dec_rd = 5'd4; dec_rs1 = 5'd1; rf_q1 = 4'd2; rf_v1 = 32'd77;
      dec_imm = 32'd12; rob_free_id = 4'd3;
      tick();
      dec_valid = 1'b0;
      checks++;
      if ({rs_enable, out_q1, out_v1, out_rob_id, out_imm} !== {1'b1, 4'd2, 32'd0, 4'd3, 32'd12}) begin
         failures++; $display("FAIL dep_packet got en=%b q=%0d v=%0d id=%0d imm=%0d want 1 2 0 3 12",
                              rs_enable, out_q1, out_v1, out_rob_id, out_imm);
      end
   endtask

   task automatic test_target_full();
      idle_inputs();
      tick();
      dec_valid = 1'b1; dec_is_ls = 1'b1; lsb_full = 1'b1; dec_openum = 6'h10; rob_free_id = 4'd5;
      #1;
      checks++;
      if ({dec_ready, rob_alloc} !== 2'b00) begin
         failures++; $display("FAIL lsb_full_stall got ready/alloc=%b want=00", {dec_ready, rob_alloc});
      end
      tick();
      checks++;
      if ({rs_enable, lsb_enable} !== 2'b00) begin
         failures++; $display("FAIL lsb_full_no_pulse got rs/lsb=%b want=00", {rs_enable, lsb_enable});
      end
      dec_is_ls = 1'b0; dec_openum = 6'h11;
      #1;
      checks++;
      if (dec_ready !== 1'b1) begin failures++; $display("FAIL rs_free_ready got=%b want=1", dec_ready); end
      tick();
      dec_valid = 1'b0;
      checks++;
      if ({rs_enable, lsb_enable, out_openum} !== {2'b10, 6'h11}) begin
         failures++; $display("FAIL rs_free_accept got rs/lsb=%b op=%h want 10 11", {rs_enable, lsb_enable}, out_openum);
      end
   endtask

   task automatic test_misbranch();
      idle_inputs();
      dec_valid = 1'b1; dec_openum = 6'h07; dec_rd = 5'd3;
      tick();
      // rs_enable now high from the accept above; flush must clear it and out_openum
      misbranch = 1'b1; dec_openum = 6'h08;
      #1;
      checks++;
      if ({dec_ready, rob_alloc, rename_en} !== 3'b000) begin
         failures++; $display("FAIL mis_block got ready/alloc/rename=%b want=000", {dec_ready, rob_alloc, rename_en});
      end
      tick();
      misbranch = 1'b0;
      #1;
      checks++;
      if ({dec_ready, rs_enable, lsb_enable, out_openum} !== {3'b000, 6'h00}) begin
         failures++; $display("FAIL mis_flush got ready=%b en=%b/%b op=%h want 0 0/0 00",
                              dec_ready, rs_enable, lsb_enable, out_openum);
      end
      tick();
      checks++;
      if ({dec_ready, rs_enable} !== 2'b10) begin
         failures++; $display("FAIL mis_recover got ready/rs_en=%b want=10", {dec_ready, rs_enable});
      end
      dec_valid = 1'b0;
   endtask

   task automatic test_rd_zero();
      idle_inputs();
      dec_valid = 1'b1; dec_rd = 5'd0; dec_rs1 = 5'd0; dec_use_rs1 = 1'b1;
      rf_q1 = 4'd5; rf_v1 = 32'd99; rob_free_id = 4'd6;
      #1;
      checks++;
      if ({rename_en, rob_alloc} !== 2'b01) begin
         failures++; $display("FAIL rd0_rename got rename/alloc=%b want=01", {rename_en, rob_alloc});
      end
      tick();
      dec_valid = 1'b0;
      checks++;
      if ({out_q1, out_v1, out_rob_id} !== {4'd0, 32'd0, 4'd6}) begin
         failures++; $display("FAIL rs1_zero got q=%0d v=%0d id=%0d want 0 0 6", out_q1, out_v1, out_rob_id);
      end
   endtask

   task automatic test_rdy_and_reset_hold();
      idle_inputs();
      dec_valid = 1'b1; dec_is_ls = 1'b1; dec_openum = 6'h21; dec_pc = 32'hABCD; rob_free_id = 4'd7;
      tick();
      rdy = 1'b0; dec_openum = 6'h22; dec_pc = 32'h1111;
      #1;
      checks++;
      if (dec_ready !== 1'b0) begin failures++; $display("FAIL rdy_low_ready got=%b want=0", dec_ready); end
      tick();
      checks++;
      if ({lsb_enable, out_openum, out_pc, out_rob_id} !== {1'b1, 6'h21, 32'hABCD, 4'd7}) begin
         failures++; $display("FAIL rdy_low_hold got en=%b op=%h pc=%h id=%0d want 1 21 abcd 7",
                              lsb_enable, out_openum, out_pc, out_rob_id);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; rdy = 1'b1; dec_valid = 1'b0;
      checks++;
      if ({lsb_enable, out_openum, out_pc, out_rob_id} !== '0) begin
         failures++; $display("FAIL rst_rdy_low got en=%b op=%h pc=%h id=%0d want zero",
                              lsb_enable, out_openum, out_pc, out_rob_id);
      end
   endtask

   // Reference: operand rules applied in priority order
   function automatic logic [ROB_W+DATA_W-1:0] ref_operand(
      input logic use_src, input logic [4:0] idx, input logic [ROB_W-1:0] q,
      input logic [DATA_W-1:0] v, input logic rr, input logic [DATA_W-1:0] rv);
      if (!use_src || idx == 0) return '0;
      if (q == 0) return {4'd0, v};
      if (rr) return {4'd0, rv};
      if (cdb_a_valid && cdb_a_id == q) return {4'd0, cdb_a_res};
      if (cdb_ls_valid && cdb_ls_id == q) return {4'd0, cdb_ls_res};
      return {q, 32'd0};
   endfunction

   task automatic test_random();
      logic m_flush;
      logic m_rs, m_lsb;
      logic [OP_W-1:0] m_op;
      logic [ROB_W+DATA_W-1:0] m_o1, m_o2;
      logic [DATA_W-1:0] m_imm, m_pc;
      logic [ROB_W-1:0] m_id;
      logic e_ready, e_fire;
      int rand_fail;
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_flush = 0; m_rs = 0; m_lsb = 0; m_op = 0; m_o1 = 0; m_o2 = 0; m_imm = 0; m_pc = 0; m_id = 0;
      rand_fail = 0;
      for (int it = 0; it < 400; it++) begin
         rst = ($urandom_range(59) == 0);
         rdy = ($urandom_range(7) != 0);
         misbranch = ($urandom_range(11) == 0);
         rob_full = ($urandom_range(7) == 0);
         rs_full = ($urandom_range(4) == 0);
         lsb_full = ($urandom_range(4) == 0);
         dec_valid = ($urandom_range(3) != 0);
         dec_is_ls = $urandom_range(1);
         dec_openum = $urandom_range(63);
         dec_rd = $urandom_range(3); dec_rs1 = $urandom_range(3); dec_rs2 = $urandom_range(3);
         dec_use_rs1 = $urandom_range(1); dec_use_rs2 = $urandom_range(1);
         dec_imm = $urandom; dec_pc = $urandom;
         rf_q1 = $urandom_range(3); rf_q2 = $urandom_range(3);
         rf_v1 = $urandom; rf_v2 = $urandom;
         rob_rdy1 = ($urandom_range(3) == 0); rob_rdy2 = ($urandom_range(3) == 0);
         rob_val1 = $urandom; rob_val2 = $urandom;
         rob_free_id = $urandom_range(15, 1);
         cdb_a_valid = $urandom_range(1); cdb_a_id = $urandom_range(3); cdb_a_res = $urandom;
         cdb_ls_valid = $urandom_range(1); cdb_ls_id = $urandom_range(3); cdb_ls_res = $urandom;
         #1;
         e_ready = rdy && !rob_full && !(dec_is_ls ? lsb_full : rs_full) && !misbranch && !m_flush;
         e_fire = dec_valid && e_ready;
         checks++;
         if ({dec_ready, rob_alloc, rename_en} !== {e_ready, e_fire, e_fire && dec_rd != 0}) begin
            failures++; rand_fail++;
            if (rand_fail < 10)
               $display("FAIL rand_comb it=%0d got ready/alloc/rename=%b want=%b", it,
                        {dec_ready, rob_alloc, rename_en}, {e_ready, e_fire, e_fire && dec_rd != 0});
         end
         if (rst) begin
            m_flush = 0; m_rs = 0; m_lsb = 0; m_op = 0; m_o1 = 0; m_o2 = 0; m_imm = 0; m_pc = 0; m_id = 0;
         end else if (rdy) begin
            if (misbranch) begin
               m_flush = 1; m_rs = 0; m_lsb = 0; m_op = 0;
            end else begin
               m_flush = 0;
               if (e_fire) begin
                  m_rs = !dec_is_ls; m_lsb = dec_is_ls; m_op = dec_openum;
                  m_o1 = ref_operand(dec_use_rs1, dec_rs1, rf_q1, rf_v1, rob_rdy1, rob_val1);
                  m_o2 = ref_operand(dec_use_rs2, dec_rs2, rf_q2, rf_v2, rob_rdy2, rob_val2);
                  m_imm = dec_imm; m_pc = dec_pc; m_id = rob_free_id;
               end else begin
                  m_rs = 0; m_lsb = 0;
               end
            end
         end
         tick();
         checks++;
         if ({rs_enable, lsb_enable, out_openum, out_q1, out_v1, out_q2, out_v2, out_imm, out_pc, out_rob_id} !==
             {m_rs, m_lsb, m_op, m_o1, m_o2, m_imm, m_pc, m_id}) begin
            failures++; rand_fail++;
            if (rand_fail < 10)
               $display("FAIL rand_packet it=%0d got en=%b%b op=%h q1v1=%h q2v2=%h id=%0d want en=%b%b op=%h q1v1=%h q2v2=%h id=%0d",
                        it, rs_enable, lsb_enable, out_openum, {out_q1, out_v1}, {out_q2, out_v2}, out_rob_id,
                        m_rs, m_lsb, m_op, m_o1, m_o2, m_id);
         end
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_basic_add();
      test_cdb_forward();
      test_dependent_chain();
      test_target_full();
      test_misbranch();
      test_rd_zero();
      test_rdy_and_reset_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
